bus_cycle_ctrl: RTL
===================

Name: bus_cycle_ctrl

Overview:
- Parametrised 8085-style bus-cycle sequencer that replaces the hard-wired ALE/RDn/WRn/address-data muxing in the CPU top.
- Core issues one request (opcode fetch, memory read/write, IO read/write); block runs T1/T2/TW/T3[/T4..] states on a multiplexed address/data bus with READY wait states and timeout, then returns data and a done/err pulse.
- The top-level owns the tri-states and drives them from the ad_out/ad_oe/ctrl_oe outputs.

Parameters:
- AW, 16, total address width; must satisfy AW > DW.
- DW, 8, data width; also the width of the multiplexed low address.
- FETCH_T, 4, T-states in an opcode fetch, legal range 4..7; T-states after T3 are idle.
- MIN_WAIT, 0, forced wait states per cycle, applied regardless of ready.
- MAX_WAIT, 255, wait-state timeout; 0 disables the timeout.

Ports:
- phi1  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  1  request; sampled only in IDLE.
- bus_type  in  3  request type: 0 OPF, 1 MRD, 2 MWR, 3 IORD, 4 IOWR, 5-7 illegal.
- addr  in  AW  request address.
- wdata  in  DW  write data.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle error pulse (illegal type or timeout).
- rdata  out  DW  read data; valid with done, held until the next read completes.
- haddr  out  AW-DW  high address.
- ad_out  out  DW  multiplexed address/data output.
- ad_oe  out  1  enable for ad_out.
- ad_in  in  DW  multiplexed bus input.
- ready  in  1  external READY.
- ALE  out  1  address latch enable.
- RDn  out  1  read strobe, active low.
- WRn  out  1  write strobe, active low.
- IOMn  out  1  1 = IO cycle, 0 = memory cycle.
- S0  out  1  status bit 0.
- S1  out  1  status bit 1.
- ctrl_oe  out  1  enable for the strobes and haddr.

Behaviour:
- States: IDLE, T1, T2, TW, T3, TX (extra fetch states), plus HOLD when HOLD_BUS_EN is defined.
- All outputs are registered.
- Reset values: state=IDLE, ALE=0, RDn=1, WRn=1, IOMn=0, S1=S0=0, ad_oe=0, ad_out=0, haddr=0, ctrl_oe=1, busy=0, done=0, err=0, rdata=0.
- IDLE, req=1, legal type: latch type, addr and wdata; next state T1.
- IDLE, req=1, illegal type: err=1 in the next cycle, no bus activity, stay IDLE.
- Status encoding (S1,S0,IOMn): OPF 1,1,0; MRD 1,0,0; MWR 0,1,0; IORD 1,0,1; IOWR 0,1,1. Status is held from T1 to the end of the cycle, then returns to 0,0,IOMn unchanged.
- T1:
  - ALE=1, ad_oe=1, ad_out=addr[DW-1:0].
  - Memory cycles: haddr=addr[AW-1:DW].
  - IO cycles: haddr = addr[DW-1:0] zero-extended or truncated to AW-DW bits.
- T2:
  - ALE=0.
  - Read/OPF: ad_oe=0, RDn=0.
  - Write: ad_out=wdata, ad_oe=1, WRn=0.
  - wait_cnt cleared to 0.
- End of T2 and of each TW:
  - go to T3 if ready=1 and wait_cnt >= MIN_WAIT;
  - otherwise go to TW and increment wait_cnt (saturating).
- TW: strobes and ad_out held.
- Timeout: in TW with MAX_WAIT != 0 and wait_cnt == MAX_WAIT and ready=0, abort:
  - next cycle IDLE with RDn=WRn=1, ad_oe=0, err=1;
  - done=0, rdata unchanged.
- T3 (read/OPF): RDn=0; rdata <= ad_in on the edge leaving T3; RDn=1 from the next cycle.
- T3 (write): WRn=0; WRn=1 and ad_oe=0 from the next cycle.
- OPF: after T3, FETCH_T-3 TX cycles with all strobes inactive; rdata is captured at the end of T3 as for reads.
- Completion: done=1 in the first IDLE cycle after the last T-state. A req in that same cycle is accepted (back-to-back).
- Throughput with zero waits: MRD/MWR/IO = 4 cycles per transfer; OPF with FETCH_T=4 = 5 cycles.
- req is ignored while busy=1; it is not queued.
- rst while a cycle is in progress: next state IDLE, all outputs to reset values, no done or err.

Optional Feature:
- Macro: HOLD_BUS_EN.
- Defined:
  - Adds ports hold (in, 1) and hlda (out, 1).
  - hold is sampled in IDLE and beats req.
  - hold=1 -> next state HOLD: hlda=1, ctrl_oe=0, ad_oe=0.
  - A hold asserted mid-cycle is honoured only on return to IDLE, and only after that cycle's done.
  - hold=0 in HOLD -> IDLE with hlda=0; a pending req is accepted in that IDLE cycle.
- Undefined: no hold/hlda ports, no HOLD state, ctrl_oe tied to 1.

Test Plan:
- MRD addr=16'h2050, ready=1 -> ALE=1 with ad_out=8'h50, haddr=8'h20 in T1; RDn low in T2-T3; ad_in=8'hA5 in T3 -> rdata=8'hA5, done 4 cycles after the req cycle; S1,S0,IOMn=1,0,0.
- IOWR addr=16'h0033, wdata=8'h7E -> haddr=8'h33, IOMn=1; ad_out=8'h7E with WRn low in T2-T3; done with no rdata change.
- MRD with ready low for 3 cycles, MIN_WAIT=0 -> exactly 3 TW states, RDn low for 5 cycles, done on the 7th cycle after acceptance.
- MAX_WAIT=4, ready stuck low -> err pulse after 4 TW, RDn=1, ad_oe=0, done never asserted, rdata unchanged.
- OPF FETCH_T=6 back-to-back with MWR, plus bus_type=6 -> OPF takes 7 cycles, MWR is accepted in OPF's done cycle, the illegal type gives an err pulse with no ALE; rst asserted during a following T2 -> all outputs at reset values next cycle.
- HOLD_BUS_EN: hold raised during MRD T2 -> cycle completes with done, then hlda=1 and ctrl_oe=0; release hold with req pending -> new T1 two cycles later.

Source files
------------

// File: rtl/bus_cycle_ctrl.sv
// 8085-style multiplexed address/data bus-cycle sequencer (T1/T2/TW/T3/TX).
// Define HOLD_BUS_EN to add the hold/hlda bus-release handshake and HOLD state.
module bus_cycle_ctrl #(
  parameter int unsigned AW       = 16,
  parameter int unsigned DW       = 8,
  parameter int unsigned FETCH_T  = 4,
  parameter int unsigned MIN_WAIT = 0,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic             phi1,
  input  logic             rst,
  input  logic             req,
  input  logic [2:0]       bus_type,
  input  logic [AW-1:0]    addr,
  input  logic [DW-1:0]    wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [DW-1:0]    rdata,
  output logic [AW-DW-1:0] haddr,
  output logic [DW-1:0]    ad_out,
  output logic             ad_oe,
  input  logic [DW-1:0]    ad_in,
  input  logic             ready,
  output logic             ALE,
  output logic             RDn,
  output logic             WRn,
  output logic             IOMn,
  output logic             S0,
  output logic             S1,
`ifdef HOLD_BUS_EN
  input  logic             hold,
  output logic             hlda,
`endif
  output logic             ctrl_oe
);

  localparam int unsigned HW      = AW - DW;
  localparam int unsigned WaitTop = (MAX_WAIT > MIN_WAIT) ? MAX_WAIT : MIN_WAIT;
  localparam int unsigned WCW     = $clog2(WaitTop + 2);
  localparam logic [2:0]  TxLoad  = 3'(FETCH_T - 4);

  localparam logic [2:0] TypeOpf  = 3'd0;
  localparam logic [2:0] TypeMrd  = 3'd1;
  localparam logic [2:0] TypeMwr  = 3'd2;
  localparam logic [2:0] TypeIord = 3'd3;
  localparam logic [2:0] TypeIowr = 3'd4;

  typedef enum logic [2:0] {
    StIdle,
    StT1,
    StT2,
    StTw,
    StT3,
`ifdef HOLD_BUS_EN
    StTx,
    StHold
`else
    StTx
`endif
  } state_e;

  state_e           state_q;
  logic [2:0]       type_q;
  logic [DW-1:0]    wdata_q;
  logic [WCW-1:0]   wait_cnt_q;
  logic [2:0]       tx_cnt_q;
  logic             min_met;
  logic             timed_out;

  // Returns {S1, S0, IOMn} for a legal request type.
  function automatic logic [2:0] status_of(input logic [2:0] t);
    case (t)
      TypeOpf:  return 3'b110;
      TypeMrd:  return 3'b100;
      TypeMwr:  return 3'b010;
      TypeIord: return 3'b101;
      TypeIowr: return 3'b011;
      default:  return 3'b000;
    endcase
  endfunction

  function automatic logic is_io(input logic [2:0] t);
    return (t == TypeIord) || (t == TypeIowr);
  endfunction

  function automatic logic is_wr(input logic [2:0] t);
    return (t == TypeMwr) || (t == TypeIowr);
  endfunction

  assign min_met   = int'(wait_cnt_q) >= int'(MIN_WAIT);
  assign timed_out = (MAX_WAIT != 0) && (int'(wait_cnt_q) == int'(MAX_WAIT));

`ifndef HOLD_BUS_EN
  assign ctrl_oe = 1'b1;
`endif

  always_ff @(posedge phi1) begin
    if (rst) begin
      state_q    <= StIdle;
      type_q     <= TypeOpf;
      wdata_q    <= '0;
      wait_cnt_q <= '0;
      tx_cnt_q   <= '0;
      ALE        <= 1'b0;
      RDn        <= 1'b1;
      WRn        <= 1'b1;
      IOMn       <= 1'b0;
      S1         <= 1'b0;
      S0         <= 1'b0;
      ad_oe      <= 1'b0;
      ad_out     <= '0;
      haddr      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
`ifdef HOLD_BUS_EN
      hlda       <= 1'b0;
      ctrl_oe    <= 1'b1;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
`ifdef HOLD_BUS_EN
          if (hold) begin
            state_q <= StHold;
            busy    <= 1'b1;
            hlda    <= 1'b1;
            ctrl_oe <= 1'b0;
            ad_oe   <= 1'b0;
          end else
`endif
          if (req) begin
            if (bus_type > TypeIowr) begin
              err <= 1'b1;
            end else begin
              state_q        <= StT1;
              type_q         <= bus_type;
              wdata_q        <= wdata;
              busy           <= 1'b1;
              ALE            <= 1'b1;
              ad_oe          <= 1'b1;
              ad_out         <= addr[DW-1:0];
              haddr          <= is_io(bus_type) ? HW'(addr[DW-1:0]) : addr[AW-1:DW];
              {S1, S0, IOMn} <= status_of(bus_type);
            end
          end
        end
        StT1: begin
          state_q    <= StT2;
          ALE        <= 1'b0;
          wait_cnt_q <= '0;
          if (is_wr(type_q)) begin
            ad_out <= wdata_q;
            WRn    <= 1'b0;
          end else begin
            ad_oe <= 1'b0;
            RDn   <= 1'b0;
          end
        end
        StT2, StTw: begin
          if (ready && min_met) begin
            state_q <= StT3;
          end else if ((state_q == StTw) && timed_out && !ready) begin
            // Abort: release the bus and report, leaving rdata untouched.
            state_q <= StIdle;
            busy    <= 1'b0;
            err     <= 1'b1;
            RDn     <= 1'b1;
            WRn     <= 1'b1;
            ad_oe   <= 1'b0;
            S1      <= 1'b0;
            S0      <= 1'b0;
          end else begin
            state_q <= StTw;
            if (wait_cnt_q != {WCW{1'b1}}) wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StT3: begin
          if (is_wr(type_q)) begin
            WRn   <= 1'b1;
            ad_oe <= 1'b0;
          end else begin
            RDn   <= 1'b1;
            rdata <= ad_in;
          end
          if (type_q == TypeOpf) begin
            state_q  <= StTx;
            tx_cnt_q <= TxLoad;
          end else begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
            S1      <= 1'b0;
            S0      <= 1'b0;
          end
        end
        StTx: begin
          if (tx_cnt_q == 3'd0) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
            S1      <= 1'b0;
            S0      <= 1'b0;
          end else begin
            tx_cnt_q <= tx_cnt_q - 3'd1;
          end
        end
`ifdef HOLD_BUS_EN
        StHold: begin
          if (!hold) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            hlda    <= 1'b0;
            ctrl_oe <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
